// File: rtl/nested_rec_rr_arbiter_if.sv
// Request/response bundle for nested_rec_rr_arbiter: NUM_REQ record sources in,
// one registered record stream plus a completed-packet counter out.
interface nested_rec_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REC_W   = 11
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*REC_W-1:0] req_rec;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic [REC_W-1:0]         out_rec;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;
    logic [15:0]              pkt_count;

    modport slave (
        input  req_valid, req_rec, out_ready,
        output req_ready, out_valid, out_rec, out_src, pkt_count
    );

    modport master (
        output req_valid, req_rec, out_ready,
        input  req_ready, out_valid, out_rec, out_src, pkt_count
    );
endinterface

// File: rtl/nested_rec_rr_arbiter.sv
// Packet-locking round-robin arbiter: forwards whole packets of nested-struct
// records from NUM_REQ requesters into one registered output stage.
module nested_rec_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nested_rec_rr_arbiter_if.slave bus
);
    localparam int REC_W = 1 + ID_W + DATA_W;
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic            last;
        logic [ID_W-1:0] id;
    } hdr_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
    } pay_t;

    typedef struct packed {
        hdr_t hdr;
        pay_t pay;
    } rec_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r,    state_s;
    logic [SRC_W-1:0]   rr_ptr_r,   rr_ptr_s;
    logic [SRC_W-1:0]   lock_idx_r, lock_idx_s;
    logic               out_valid_r, out_valid_s;
    rec_t               out_rec_r,  out_rec_s;
    logic [SRC_W-1:0]   out_src_r,  out_src_s;
    logic [15:0]        pkt_count_r, pkt_count_s;

    logic               can_load_s;
    logic [SRC_W:0]     probe_s;
    logic [SRC_W-1:0]   winner_s;
    logic               winner_found_s;
    logic [SRC_W-1:0]   sel_idx_s;
    logic               sel_en_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic               taken_s;
    rec_t               taken_rec_s;

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        if (idx == SRC_W'(NUM_REQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + SRC_W'(1);
        end
    endfunction

    assign can_load_s = !out_valid_r || bus.out_ready;

    // Round-robin search for the first valid requester starting at rr_ptr.
    always_comb begin
        winner_s       = '0;
        winner_found_s = 1'b0;
        probe_s        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe_s = {1'b0, rr_ptr_r} + (SRC_W + 1)'(k);
            if (probe_s >= (SRC_W + 1)'(NUM_REQ)) begin
                probe_s = probe_s - (SRC_W + 1)'(NUM_REQ);
            end else begin
                probe_s = probe_s;
            end
            if (!winner_found_s && bus.req_valid[probe_s[SRC_W-1:0]]) begin
                winner_s       = probe_s[SRC_W-1:0];
                winner_found_s = 1'b1;
            end else begin
                winner_found_s = winner_found_s;
            end
        end
    end

    // Grant: a held lock overrides the round-robin winner; ready is forced low in reset.
    always_comb begin
        req_ready_s = '0;
        if (state_r == ST_LOCKED) begin
            sel_idx_s = lock_idx_r;
            sel_en_s  = 1'b1;
        end else begin
            sel_idx_s = winner_s;
            sel_en_s  = winner_found_s;
        end
        if (rst_n && sel_en_s) begin
            req_ready_s[sel_idx_s] = can_load_s;
        end else begin
            req_ready_s = '0;
        end
        taken_s     = req_ready_s[sel_idx_s] && bus.req_valid[sel_idx_s];
        taken_rec_s = rec_t'(bus.req_rec[int'(sel_idx_s) * REC_W +: REC_W]);
    end

    // Packet-lock FSM next state; rr_ptr moves only when a packet's last beat is taken.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        lock_idx_s = lock_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (taken_s && taken_rec_s.hdr.last) begin
                    rr_ptr_s = next_idx(winner_s);
                end else if (taken_s) begin
                    state_s    = ST_LOCKED;
                    lock_idx_s = winner_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (taken_s && taken_rec_s.hdr.last) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = next_idx(lock_idx_r);
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                rr_ptr_s   = '0;
                lock_idx_s = '0;
            end
        endcase
    end

    // Output stage: reload on a taken beat, otherwise drain or hold under backpressure.
    always_comb begin
        out_valid_s = out_valid_r;
        out_rec_s   = out_rec_r;
        out_src_s   = out_src_r;
        pkt_count_s = pkt_count_r;
        if (taken_s) begin
            out_valid_s = 1'b1;
            out_rec_s   = taken_rec_s;
            out_src_s   = sel_idx_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
        if (out_valid_r && bus.out_ready && out_rec_r.hdr.last) begin
            pkt_count_s = pkt_count_r + 16'd1;
        end else begin
            pkt_count_s = pkt_count_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            lock_idx_r  <= '0;
            out_valid_r <= 1'b0;
            out_rec_r   <= '0;
            out_src_r   <= '0;
            pkt_count_r <= 16'd0;
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            lock_idx_r  <= lock_idx_s;
            out_valid_r <= out_valid_s;
            out_rec_r   <= out_rec_s;
            out_src_r   <= out_src_s;
            pkt_count_r <= pkt_count_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_rec   = out_rec_r;
    assign bus.out_src   = out_src_r;
    assign bus.pkt_count = pkt_count_r;

endmodule

// File: tb/tb_nested_rec_rr_arbiter.sv
// Scenario bench for nested_rec_rr_arbiter: directed cases plus random traffic,
// all compared against a packet-level reference model.
module tb_nested_rec_rr_arbiter;
    localparam int N  = 4;
    localparam int RW = 11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nested_rec_rr_arbiter_if #(.NUM_REQ(N), .REC_W(RW)) bus ();

    nested_rec_rr_arbiter #(.NUM_REQ(N), .ID_W(2), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packet owner, round-robin start point, one-entry output slot.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_ov;
    logic [10:0] m_rec;
    logic [1:0]  m_src;
    logic [15:0] m_cnt;

    function automatic logic [10:0] rec_of(int i);
        return bus.req_rec[i*RW +: RW];
    endfunction

    function automatic int model_grant();
        if (m_locked) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int g;
        r = 4'b0000;
        if (!rst_n) return r;
        g = model_grant();
        if (g >= 0) r[g] = !m_ov || bus.out_ready;
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        m_ov = 1'b0; m_rec = 11'h000; m_src = 2'd0; m_cnt = 16'h0000;
    endtask

    // Advance one clock edge and move the model the same way; returns at edge+1.
    task automatic step();
        int g;
        bit can, taken;
        @(posedge clk);
        g     = model_grant();
        can   = !m_ov || bus.out_ready;
        taken = (g >= 0) && can && bus.req_valid[g];
        if (m_ov && bus.out_ready && m_rec[10]) m_cnt = m_cnt + 16'd1;
        if (taken) begin
            m_rec = rec_of(g);
            m_src = 2'(g);
            m_ov  = 1'b1;
            if (m_rec[10]) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end else if (m_ov && bus.out_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_rec   = 44'h0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        bus.req_valid = 4'b1111;
        bus.req_rec   = 44'hFFF_FFFF_FFFF;
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count} !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b rec=%h src=%0d cnt=%h exp all zero",
                     bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_rr_basic();
        int exp_g[4] = '{0, 2, 0, 2};
        apply_reset();
        bus.out_ready = 1'b1;
        bus.req_rec   = {11'h4D3, 11'h6B2, 11'h5C1, 11'h4A0};
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (bus.req_ready !== (4'b0001 << exp_g[k]) || bus.req_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rr_grant k=%0d got %b exp %b", k, bus.req_ready, 4'b0001 << exp_g[k]);
            end
            step();
            n_tests++;
            if (bus.out_src !== 2'(exp_g[k]) || bus.out_valid !== 1'b1 ||
                bus.out_rec !== m_rec) begin
                n_fail++;
                $display("FAIL rr_src k=%0d got src=%0d rec=%h exp src=%0d rec=%h",
                         k, bus.out_src, bus.out_rec, exp_g[k], m_rec);
            end
        end
        bus.req_valid = 4'b0000;
        step();
        n_tests++;
        if (bus.pkt_count !== 16'd4 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_count got cnt=%0d v=%b exp cnt=4 v=0", bus.pkt_count, bus.out_valid);
        end
    endtask

    task automatic test_locked_packet();
        logic [10:0] beats[3] = '{11'h111, 11'h122, 11'h533};
        apply_reset();
        bus.out_ready = 1'b1;
        bus.req_rec   = {11'h4D3, 11'h6B2, 11'h000, 11'h400};
        bus.req_valid = 4'b0001;
        #1; step();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            bus.req_rec[1*RW +: RW] = beats[k];
            #1;
            n_tests++;
            if (bus.req_ready !== 4'b0010) begin
                n_fail++; $display("FAIL lock_ready k=%0d got %b exp 0010", k, bus.req_ready);
            end
            step();
            n_tests++;
            if (bus.out_src !== 2'd1 || bus.out_rec !== beats[k] || bus.pkt_count !== m_cnt) begin
                n_fail++;
                $display("FAIL lock_beat k=%0d got src=%0d rec=%h cnt=%0d exp src=1 rec=%h cnt=%0d",
                         k, bus.out_src, bus.out_rec, bus.pkt_count, beats[k], m_cnt);
            end
        end
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL lock_next got %b exp 0100", bus.req_ready);
        end
        step();
        n_tests++;
        if (bus.out_src !== 2'd2 || bus.out_rec !== 11'h6B2) begin
            n_fail++; $display("FAIL lock_next_src got %0d/%h exp 2/6b2", bus.out_src, bus.out_rec);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.out_ready = 1'b0;
        bus.req_rec   = {33'h0, 11'h5A5};
        bus.req_valid = 4'b0001;
        #1; step();
        bus.req_rec = {33'h0, 11'h4C3};
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (bus.req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready k=%0d got %b exp 0000", k, bus.req_ready);
            end
            step();
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_rec !== 11'h5A5 || bus.out_src !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_hold k=%0d got v=%b rec=%h exp v=1 rec=5a5", k, bus.out_valid, bus.out_rec);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL bp_release got %b exp 0001", bus.req_ready);
        end
        step();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_rec !== 11'h4C3 || bus.pkt_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_reload got v=%b rec=%h cnt=%0d exp v=1 rec=4c3 cnt=1",
                     bus.out_valid, bus.out_rec, bus.pkt_count);
        end
    endtask

    task automatic test_lock_stall();
        apply_reset();
        bus.out_ready = 1'b1;
        bus.req_rec   = {11'h0F0, 22'h0, 11'h401};
        bus.req_valid = 4'b1000;
        #1; step();
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (bus.req_ready[0] !== 1'b0 || bus.req_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL stall_ready k=%0d got %b exp %b", k, bus.req_ready, model_ready());
            end
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count} !== {m_ov, m_rec, m_src, m_cnt}) begin
                n_fail++;
                $display("FAIL stall_out k=%0d got v=%b src=%0d exp v=%b src=%0d",
                         k, bus.out_valid, bus.out_src, m_ov, m_src);
            end
        end
        bus.req_valid = 4'b1001;
        bus.req_rec[3*RW +: RW] = 11'h4F1;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL stall_resume got %b exp 1000", bus.req_ready);
        end
        step();
        n_tests++;
        if (bus.out_src !== 2'd3 || bus.out_rec !== 11'h4F1) begin
            n_fail++; $display("FAIL stall_last got %0d/%h exp 3/4f1", bus.out_src, bus.out_rec);
        end
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL stall_wrap got %b exp 0001", bus.req_ready);
        end
        step();
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        bus.out_ready = 1'b1;
        bus.req_rec   = {11'h000, 11'h2AB, 11'h000, 11'h401};
        bus.req_valid = 4'b0001;
        #1; step();
        bus.req_valid = 4'b0000;
        #1; step();
        bus.req_valid = 4'b0100;
        #1; step();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        #1; step();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.pkt_count !== 16'd1 || bus.out_src !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_pre got v=%b cnt=%0d src=%0d exp v=1 cnt=1 src=2",
                     bus.out_valid, bus.pkt_count, bus.out_src);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count} !== 30'h0 ||
            bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b rec=%h src=%0d cnt=%0d rdy=%b exp all zero",
                     bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count, bus.req_ready);
        end
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_rec   = {11'h000, 11'h422, 11'h411, 11'h000};
        bus.req_valid = 4'b0110;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL mid_first_grant got %b exp 0010", bus.req_ready);
        end
        step();
        n_tests++;
        if (bus.out_src !== 2'd1 || bus.out_rec !== 11'h411) begin
            n_fail++; $display("FAIL mid_first_out got %0d/%h exp 1/411", bus.out_src, bus.out_rec);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                bus.req_rec[i*RW +: RW] = {($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, 10'($urandom)};
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_tests++;
            if (bus.req_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready c=%0d got %b exp %b", c, bus.req_ready, model_ready());
            end
            step();
            n_tests++;
            if ({bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count} !== {m_ov, m_rec, m_src, m_cnt}) begin
                n_fail++;
                $display("FAIL rand_out c=%0d got v=%b rec=%h src=%0d cnt=%0d exp v=%b rec=%h src=%0d cnt=%0d",
                         c, bus.out_valid, bus.out_rec, bus.out_src, bus.pkt_count, m_ov, m_rec, m_src, m_cnt);
            end
        end
    endtask

    task automatic test_count_wrap();
        apply_reset();
        bus.out_ready = 1'b1;
        bus.req_rec   = {33'h0, 11'h4FF};
        bus.req_valid = 4'b0001;
        #1;
        repeat (65536) step();
        n_tests++;
        if (bus.pkt_count !== 16'hFFFF || bus.pkt_count !== m_cnt) begin
            n_fail++; $display("FAIL wrap_pre got %h exp ffff", bus.pkt_count);
        end
        step();
        n_tests++;
        if (bus.pkt_count !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero got %h exp 0000", bus.pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_locked_packet();
        test_backpressure();
        test_lock_stall();
        test_reset_mid_packet();
        test_random();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
